// File: rtl/daq_event_framer.sv
// rtl/daq_event_framer.sv - DAQ event framer: checks HDR1/HDR2/payload/TRL1/TRL2 framing into a FIFO
//
// Optional build macro: DAQ_EVENT_FRAMER_WCNT_EN appends a {4'hF, count[11:0]}
// word after TRL2 on the next sync cycle. Without it, events end at TRL2.
//
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   sync, din_write, din input word strobe (qualified by sync) and 16-bit word
//   dout, dout_valid     FIFO head word and FIFO-not-empty
//   dout_ready           consumer accepts dout (read is independent of sync)
//   fifo_level           current FIFO occupancy (0 .. 2^DEPTH_LOG2)
//   ev_done              one-clk pulse after the last word of an event is written
//   err_frame, err_ovfl  sticky framing / overflow flags
//   err_clear            synchronous clear of both sticky flags (wins over a set)

module daq_event_framer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync,
    input  logic                  din_write,
    input  logic [15:0]           din,
    output logic [15:0]           dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  ev_done,
    output logic                  err_frame,
    output logic                  err_ovfl,
    input  logic                  err_clear
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR2,
        S_PAYLOAD,
        S_TRL2,
        S_WCNT
    } state_t;

    state_t state, state_nxt;

    logic [11:0] count, count_nxt, count_inc;
    logic        accept;
    logic        is_hdr1, is_hdr2, is_trl1, is_trl2, is_data;
    logic        wr_req, frame_set, done_set;
    logic [15:0] wr_data;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, rd_en, wr_en, ovfl_set;

    assign accept    = sync && din_write;
    assign is_hdr1   = (din[15:8] == 8'hA0);
    assign is_hdr2   = (din[15:8] == 8'h80);
    assign is_trl1   = (din[15:8] == 8'hE0);
    assign is_trl2   = (din[15:8] == 8'hC0);
    assign is_data   = !(is_hdr1 || is_hdr2 || is_trl1 || is_trl2);
    assign count_inc = (count == 12'hFFF) ? count : count + 12'd1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; an overflow drop does not affect state progression
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept && is_hdr1) state_nxt = S_HDR2;
            S_HDR2:    if (accept) state_nxt = is_hdr2 ? S_PAYLOAD : S_IDLE;
            S_PAYLOAD: begin
                if (accept && is_trl1)      state_nxt = S_TRL2;
                else if (accept && is_hdr1) state_nxt = S_HDR2;
            end
            S_TRL2: begin
                if (accept) begin
`ifdef DAQ_EVENT_FRAMER_WCNT_EN
                    state_nxt = is_trl2 ? S_WCNT : S_IDLE;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef DAQ_EVENT_FRAMER_WCNT_EN
            S_WCNT:    if (sync) state_nxt = S_IDLE;
`endif
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Output logic: FIFO write request, count update, error/done strobes
    always_comb begin
        wr_req    = 1'b0;
        wr_data   = din;
        frame_set = 1'b0;
        done_set  = 1'b0;
        count_nxt = count;
        case (state)
            S_IDLE: begin
                if (accept && is_hdr1) begin
                    wr_req    = 1'b1;
                    count_nxt = 12'd1;
                end else if (accept) begin
                    frame_set = 1'b1;
                end
            end
            S_HDR2: begin
                if (accept && is_hdr2) begin
                    wr_req    = 1'b1;
                    count_nxt = count_inc;
                end else if (accept) begin
                    frame_set = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (accept && (is_data || is_trl1)) begin
                    wr_req    = 1'b1;
                    count_nxt = count_inc;
                end else if (accept && is_hdr1) begin
                    // Resync: the new header starts a fresh event
                    wr_req    = 1'b1;
                    frame_set = 1'b1;
                    count_nxt = 12'd1;
                end else if (accept) begin
                    // Stray HDR2/TRL2 inside a payload is dropped, event continues
                    frame_set = 1'b1;
                end
            end
            S_TRL2: begin
                if (accept && is_trl2) begin
                    wr_req    = 1'b1;
                    count_nxt = count_inc;
`ifndef DAQ_EVENT_FRAMER_WCNT_EN
                    done_set  = 1'b1;
`endif
                end else if (accept) begin
                    frame_set = 1'b1;
                end
            end
`ifdef DAQ_EVENT_FRAMER_WCNT_EN
            S_WCNT: begin
                if (sync) begin
                    wr_req    = 1'b1;
                    wr_data   = {4'hF, count};
                    done_set  = 1'b1;
                    frame_set = din_write;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) count <= 12'd0;
        else          count <= count_nxt;
    end

    // FIFO: a full FIFO still accepts a write when the head is read the same clk
    assign dout_valid = (fifo_level != '0);
    assign full       = (fifo_level == (DEPTH_LOG2+1)'(DEPTH));
    assign rd_en      = dout_valid && dout_ready;
    assign wr_en      = wr_req && (!full || rd_en);
    assign ovfl_set   = wr_req && full && !rd_en;
    assign dout       = dout_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      fifo_level <= fifo_level + 1'b1;
            else if (!wr_en && rd_en) fifo_level <= fifo_level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_done   <= 1'b0;
            err_frame <= 1'b0;
            err_ovfl  <= 1'b0;
        end else begin
            ev_done   <= done_set;
            err_frame <= err_clear ? 1'b0 : (err_frame | frame_set);
            err_ovfl  <= err_clear ? 1'b0 : (err_ovfl | ovfl_set);
        end
    end

endmodule

// File: tb/tb_daq_event_framer.sv
// tb/tb_daq_event_framer.sv - randomized and directed self-checking bench for daq_event_framer

module tb_daq_event_framer;

    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
`ifdef DAQ_EVENT_FRAMER_WCNT_EN
    localparam bit WCNT = 1'b1;
`else
    localparam bit WCNT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sync = 1'b0;
    logic          din_write = 1'b0;
    logic [15:0]   din = 16'h0;
    logic [15:0]   dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DL:0]   fifo_level;
    logic          ev_done;
    logic          err_frame;
    logic          err_ovfl;
    logic          err_clear = 1'b0;

    always #5 clk = ~clk;

    daq_event_framer #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset_n(reset_n), .sync(sync), .din_write(din_write), .din(din),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_level(fifo_level), .ev_done(ev_done), .err_frame(err_frame),
        .err_ovfl(err_ovfl), .err_clear(err_clear)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model. "lastc" is the class of the last word the current event
    // took (0 = no event open; 5 = TRL2 taken, count word still owed).
    // Classes: 1=HDR1 2=HDR2 3=DATA 4=TRL1 5=TRL2.
    logic [15:0] mq[$];
    logic [15:0] out_log[$];
    int          lastc = 0;
    int          mcnt = 0;
    bit          m_ef = 0, m_eo = 0, m_done = 0;
    int          ev_pulses = 0;

    function automatic int cls_of(input logic [15:0] w);
        case (w[15:8])
            8'hA0:   return 1;
            8'h80:   return 2;
            8'hE0:   return 4;
            8'hC0:   return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v < 4095) ? v + 1 : 4095;
    endfunction

    always @(posedge clk) begin
        bit          rd, wreq, fr, dn, full;
        logic [15:0] wd;
        int          c;
        if (!reset_n) begin
            mq.delete();
            lastc = 0; mcnt = 0; m_ef = 0; m_eo = 0; m_done = 0;
        end else begin
            rd   = (mq.size() > 0) && dout_ready;
            full = (mq.size() >= DEPTH);
            wreq = 0; fr = 0; dn = 0; wd = din;
            if (lastc == 5 && sync) begin
                wreq = 1; wd = {4'hF, 12'(mcnt)}; dn = 1; lastc = 0; fr = din_write;
            end else if (sync && din_write) begin
                c = cls_of(din);
                if (lastc == 0) begin
                    if (c == 1) begin wreq = 1; mcnt = 1; lastc = 1; end
                    else fr = 1;
                end else if (lastc == 1) begin
                    if (c == 2) begin wreq = 1; mcnt = sat_inc(mcnt); lastc = 2; end
                    else begin fr = 1; lastc = 0; end
                end else if (lastc == 2 || lastc == 3) begin
                    if (c == 3 || c == 4) begin wreq = 1; mcnt = sat_inc(mcnt); lastc = c; end
                    else if (c == 1) begin fr = 1; wreq = 1; mcnt = 1; lastc = 1; end
                    else fr = 1;
                end else if (lastc == 4) begin
                    if (c == 5) begin
                        wreq = 1; mcnt = sat_inc(mcnt);
                        if (WCNT) lastc = 5;
                        else begin lastc = 0; dn = 1; end
                    end else begin fr = 1; lastc = 0; end
                end
            end
            if (rd) out_log.push_back(mq.pop_front());
            if (wreq && (!full || rd)) mq.push_back(wd);
            m_ef   = err_clear ? 1'b0 : (m_ef | fr);
            m_eo   = err_clear ? 1'b0 : (m_eo | (wreq && full && !rd));
            m_done = dn;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("dout_valid", dout_valid, (mq.size() > 0));
            chk("dout", dout, (mq.size() > 0) ? mq[0] : 16'h0);
            chk("fifo_level", fifo_level, mq.size());
            chk("ev_done", ev_done, m_done);
            chk("err_frame", err_frame, m_ef);
            chk("err_ovfl", err_ovfl, m_eo);
            if (ev_done) ev_pulses++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        sync = 1; din_write = 1; din = w;
        step();
        din_write = 0;
    endtask

    task automatic send_gated(input logic [15:0] w);
        din = w; din_write = 1;
        for (int k = 0; k < 4; k++) begin
            sync = (k == 3);
            step();
        end
        din_write = 0; sync = 0;
    endtask

    task automatic drain(input int n);
        sync = 1; din_write = 0; dout_ready = 1;
        repeat (n) step();
    endtask

    task automatic start_test;
        err_clear = 1; step(); err_clear = 0;
        out_log.delete();
        ev_pulses = 0;
    endtask

    task automatic check_log(input string name, input logic [15:0] exp[$]);
        chk({name, "_len"}, out_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk($sformatf("%s_w%0d", name, i), out_log[i], exp[i]);
    endtask

    logic [15:0] exp[$];
    logic [15:0] ev_norm[$];

    initial begin
        ev_norm = '{16'hA005, 16'h8003, 16'h4123, 16'h4456, 16'hE000, 16'hC002};

        repeat (3) step();
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_ev_done", ev_done, 0);
        chk("rst_err_frame", err_frame, 0);
        chk("rst_err_ovfl", err_ovfl, 0);
        reset_n = 1;
        step();

        // Normal event
        dout_ready = 1;
        start_test();
        foreach (ev_norm[i]) send(ev_norm[i]);
        drain(20);
        exp = ev_norm;
        if (WCNT) exp.push_back(16'hF006);
        check_log("normal", exp);
        chk("normal_ev_done_cnt", ev_pulses, 1);
        chk("normal_err_frame", err_frame, 0);
        chk("normal_err_ovfl", err_ovfl, 0);

        // Missing header
        start_test();
        send(16'h4123);
        step();
        chk("nohdr_err_frame", err_frame, 1);
        chk("nohdr_level", fifo_level, 0);
        err_clear = 1; step(); err_clear = 0;
        chk("nohdr_cleared", err_frame, 0);

        // Resync
        start_test();
        exp = '{16'hA001, 16'h8000, 16'h4111, 16'hA002, 16'h8000, 16'hE000, 16'hC000};
        foreach (exp[i]) send(exp[i]);
        drain(20);
        if (WCNT) exp.push_back(16'hF004);
        chk("resync_err_frame", err_frame, 1);
        check_log("resync", exp);

        // Overflow
        start_test();
        dout_ready = 0;
        exp = {};
        send(16'hA010); exp.push_back(16'hA010);
        send(16'h8000); exp.push_back(16'h8000);
        for (int i = 0; i < 16; i++) begin
            send(16'h4000 + 16'(i));
            if (i < 14) exp.push_back(16'h4000 + 16'(i));
        end
        send(16'hE000);
        send(16'hC000);
        sync = 1; din_write = 0;
        repeat (3) step();
        chk("ovfl_level", fifo_level, 16);
        chk("ovfl_err_ovfl", err_ovfl, 1);
        drain(24);
        check_log("ovfl", exp);

        // Sync gate
        start_test();
        sync = 0; din_write = 1; din = 16'hA077;
        repeat (3) step();
        chk("gate_level", fifo_level, 0);
        chk("gate_valid", dout_valid, 0);
        din_write = 0;
        foreach (ev_norm[i]) send_gated(ev_norm[i]);
        for (int k = 0; k < 8; k++) begin
            sync = (k % 4 == 3);
            step();
        end
        drain(20);
        exp = ev_norm;
        if (WCNT) exp.push_back(16'hF006);
        check_log("gate", exp);
        chk("gate_ev_done_cnt", ev_pulses, 1);
        chk("gate_err_frame", err_frame, 0);

        // Reset mid-event
        start_test();
        dout_ready = 0;
        send(16'hA005);
        send(16'h8003);
        reset_n = 0;
        step();
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_ev_done", ev_done, 0);
        reset_n = 1;
        step();
        chk("midrst_no_done", ev_pulses, 0);
        out_log.delete();
        exp = '{16'hA021, 16'h8001, 16'h4555, 16'hE000, 16'hC003};
        foreach (exp[i]) send(exp[i]);
        drain(20);
        if (WCNT) exp.push_back(16'hF005);
        check_log("midrst", exp);
        chk("midrst_ev_done_cnt", ev_pulses, 1);

        // Randomized traffic, biased towards well-formed events
        for (int n = 0; n < 4000; n++) begin
            int r, c;
            sync       = ($urandom % 4) != 0;
            din_write  = $urandom % 2;
            dout_ready = ($urandom % 10) < 6;
            err_clear  = ($urandom % 40) == 0;
            if (($urandom % 5) != 0) begin
                case (lastc)
                    0:       c = 1;
                    1:       c = 2;
                    4:       c = 5;
                    default: c = (($urandom % 8) == 0) ? 4 : 3;
                endcase
            end else begin
                c = 1 + int'($urandom % 5);
            end
            r = int'($urandom % 256);
            case (c)
                1:       din = {8'hA0, 8'(r)};
                2:       din = {8'h80, 8'(r)};
                4:       din = {8'hE0, 8'(r)};
                5:       din = {8'hC0, 8'(r)};
                default: din = {4'h4, 4'($urandom % 4), 8'(r)};
            endcase
            if (($urandom % 400) == 0) reset_n = 0;
            step();
            reset_n = 1;
        end
        err_clear = 0;
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/daq_event_framer.md
DAQ_EVENT_FRAMER -- requirements
Module: daq_event_framer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, setting the output FIFO to 2^DEPTH_LOG2 16-bit words.
REQ-002 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port sync  input  1  clock enable qualifying din_write, shared with the soft TBM readout.
REQ-005 SHALL have port din_write  input  1  input word strobe, valid only when sync=1; driven from the TBM daq_write.
REQ-006 SHALL have port din  input  16  input word; driven from the TBM daq_data or the merged ROC data path.
REQ-007 SHALL have port dout  output  16  FIFO head word.
REQ-008 SHALL have port dout_valid  output  1  FIFO not empty.
REQ-009 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-010 SHALL have port fifo_level  output  DEPTH_LOG2+1  current FIFO occupancy.
REQ-011 SHALL have port ev_done  output  1  one-clk pulse when an event is completely written.
REQ-012 SHALL have port err_frame  output  1  sticky framing-error flag.
REQ-013 SHALL have port err_ovfl  output  1  sticky FIFO-overflow flag.
REQ-014 SHALL have port err_clear  input  1  synchronous clear of both sticky flags.

Function
REQ-015 SHALL accept an input word only when sync && din_write; the word class is din[15:8]: A0=HDR1, 80=HDR2, E0=TRL1, C0=TRL2, anything else=DATA.
REQ-016 SHALL implement the FSM states IDLE, HDR2, PAYLOAD, TRL2 and WCNT, with all transitions taken on accepted words except where stated.
REQ-017 IDLE: HDR1 SHALL be written with count=1 and the FSM SHALL go to HDR2; any other word SHALL be dropped and set err_frame.
REQ-018 HDR2: HDR2 SHALL be written and the FSM SHALL go to PAYLOAD; any other word SHALL be dropped, set err_frame, and return to IDLE.
REQ-019 PAYLOAD: DATA SHALL be written; TRL1 SHALL be written and the FSM SHALL go to TRL2; HDR1 SHALL set err_frame, be written as a fresh header with count=1, and go to HDR2 (resync).
REQ-020 TRL2: TRL2 SHALL be written and the FSM SHALL go to WCNT if the macro is defined, otherwise to IDLE with an ev_done pulse; any other word SHALL be dropped, set err_frame, and return to IDLE.
REQ-021 WCNT: on the next sync=1 cycle, the framer SHALL write {4'hF, count[11:0]}, pulse ev_done and go to IDLE; a din_write in that cycle SHALL be dropped and set err_frame.
REQ-022 count SHALL be 12 bits, SHALL increment once per word written to the event including header and trailers, and SHALL saturate at 0xFFF.
REQ-023 A FIFO write SHALL occur the same clk the word is accepted; the FIFO read SHALL occur on dout_valid && dout_ready, independent of sync.
REQ-024 When full, a write SHALL succeed only if a read occurs in the same clk; otherwise the word SHALL be dropped, err_ovfl set, count still incremented, and FSM state unaffected.
REQ-025 A read and a write in the same clk SHALL leave fifo_level unchanged; an empty FIFO SHALL give dout_valid=0.
REQ-026 Data SHALL reach dout at the earliest one clk after the write (registered FIFO, no bypass).
REQ-027 err_clear SHALL take priority over a simultaneous set.

Reset
REQ-028 On reset_n=0: FSM=IDLE, count=0, FIFO empty, fifo_level=0, dout_valid=0, dout=0, ev_done=0, err_frame=0, err_ovfl=0.
REQ-029 Reset during an event SHALL discard all partial and buffered words, with no ev_done pulse.

Configuration
REQ-030 SHALL support the macro DAQ_EVENT_FRAMER_WCNT_EN: when defined, the WCNT state and the trailing word-count word exist; when undefined, events end at TRL2 and no count word is produced.

Verification
REQ-031 SHALL cover a normal event: sync=1 always; A005,8003,4123,4456,E000,C002 with dout_ready=1 -> same 6 words out, then F006 (macro on), ev_done=1 once, no errors.
REQ-032 SHALL cover a missing header: 4123 in IDLE -> dropped, err_frame=1, fifo_level=0; err_clear -> err_frame=0.
REQ-033 SHALL cover resync: A001,8000,4111,A002,8000,E000,C000 -> err_frame=1; output A001,8000,4111,A002,8000,E000,C000,F004.
REQ-034 SHALL cover overflow: DEPTH_LOG2=4, dout_ready=0, an event of 20 words -> fifo_level=16, err_ovfl=1, count word F014 dropped; then dout_ready=1 -> 16 words out in order.
REQ-035 SHALL cover a sync gate: din_write=1 with sync=0 -> no write; sync every 4th clk -> identical output to REQ-031.
REQ-036 SHALL cover reset mid-event: reset_n=0 after 8003 -> dout_valid=0, no ev_done; next A0xx event framed correctly.
